lmem_arbiter: RTL and testbench
===============================

# lmem_arbiter

Round-robin arbiter for the single shared layer-memory port: csel, caddr_wr, cdata_wr, cwr, caddr_rd, crd, cdata_rd.
- It sits between the layer-memory bus and up to NREQ engines that all need that port, for example the convolution writer, the max-pool reader/writer and the flatten writer.
- It grants one access per cycle and registers the winning command onto the bus.
- It returns read data tagged with the requester ID.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..4)
- AW, 12, layer-memory address width
- DW, 20, layer-memory data width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester access request
- we  in  NREQ  1 = write, 0 = read
- sel  in  3*NREQ  csel value per requester; requester i uses bits [3i+2:3i]
- addr  in  AW*NREQ  address per requester
- wdata  in  DW*NREQ  write data per requester
- lock  in  NREQ  burst lock; see Configuration
- gnt  out  NREQ  one-hot grant, combinational
- rvalid  out  1  read data valid
- rid  out  2  requester index owning rdata
- rdata  out  DW  read data; equals cdata_rd
- csel  out  3  memory select, registered
- cwr  out  1  write strobe, registered
- caddr_wr  out  AW  write address, registered
- cdata_wr  out  DW  write data, registered
- crd  out  1  read strobe, registered
- caddr_rd  out  AW  read address, registered
- cdata_rd  in  DW  memory read data, valid the cycle after crd

## Operation
- **Transfer.** A transfer occurs in a cycle where req[i] and gnt[i] are both 1.
  - The requester holds we, sel, addr and wdata stable while req[i]=1.
  - It may drop req[i] before it is granted (withdraw); no side effects result.
- **Grant.** gnt is one-hot or zero.
  - Priority starts at pointer ptr and goes ptr, ptr+1, … mod NREQ.
  - After a grant to i, ptr becomes (i+1) mod NREQ.
  - With no requests, gnt is 0 and ptr holds.
- **Write command.** At the granting edge: cwr=1, crd=0, csel=sel[i], caddr_wr=addr[i], cdata_wr=wdata[i].
- **Read command.** At the granting edge: crd=1, cwr=0, csel=sel[i], caddr_rd=addr[i].
  - One cycle later: rvalid=1, rid=i, rdata=cdata_rd.
- **Idle cycle.** cwr=0 and crd=0. csel, the addresses and cdata_wr hold their last values.
- **Exclusivity.** cwr and crd are never both 1.
- **State machine (ptr logic plus lock owner).**
  - IDLE: no grant last cycle.
  - GRANT: a single-cycle grant.
  - LOCKED (macro only): the owner is the sole eligible requester.
  - Transitions: IDLE→GRANT when any req is high. GRANT→GRANT or IDLE per req. GRANT→LOCKED when the granted requester has lock=1 (macro only).
- **Reset.**
  - Output values: csel=0, cwr=0, crd=0, caddr_wr=0, caddr_rd=0, cdata_wr=0, rvalid=0, rid=0, gnt=0, ptr=0.
  - Reset mid-burst discards any in-flight read; rvalid stays 0 after reset is released.

## Timing
- Grant to bus command latency: 1 cycle.
- Grant to rvalid latency: 2 cycles.
  - Cycle T: gnt. T+1: crd/caddr_rd on the bus. T+2: rvalid/rdata.
- Throughput: one access per cycle; back-to-back reads from different requesters give back-to-back rvalid with the matching rid.
- Fairness without lock: a requester holding req waits at most NREQ-1 cycles for its grant.
- Requests arriving at the same time resolve purely by ptr; there is no fixed priority.
- Read data is not buffered. The requester must accept rdata in the rvalid cycle.

## Configuration
- Macro: LMEM_ARB_LOCK_EN.
- **Defined.**
  - If the granted requester i has lock[i]=1 in its grant cycle, i stays the only eligible requester while req[i]=1 (state LOCKED).
  - The burst ends on the first grant with lock[i]=0, or when req[i]=0. The arbiter then returns to round-robin with ptr=(i+1) mod NREQ.
  - Use case: the 4-read max-pool window followed by its write.
- **Undefined.**
  - The lock input is ignored and the LOCKED state does not exist.
  - Every access is arbitrated independently.

## Test plan
- Reset: assert reset_n=0 mid-read → all outputs 0 immediately; after release, no rvalid appears.
- Round-robin: req=3'b111, all reads, addr 0x010/0x020/0x030 → gnt order 001, 010, 100, 001. caddr_rd sequence 0x010, 0x020, 0x030. rid 0, 1, 2 at T+2.
- Write path: requester 1 writes sel=3'b011, addr 0x3FF, wdata 0x0ABCD → next cycle csel=3, caddr_wr=0x3FF, cdata_wr=0x0ABCD, cwr=1, crd=0.
- Withdraw: req[2] pulses for 1 cycle while requester 0 is granted → req[2] never granted; ptr unaffected by requester 2.
- Lock (LMEM_ARB_LOCK_EN): requester 1 issues 4 reads with lock=1, then a write with lock=0, while req[0]=1 → 5 consecutive gnt[1]; then gnt[0].
- Read data: memory returns 0xFFFFF for a read by requester 2 → rvalid=1, rid=2, rdata=0xFFFFF exactly 2 cycles after the grant.

Source files
------------

// File: rtl/lmem_arbiter.sv
// lmem_arbiter: round-robin arbiter for the shared layer-memory port.
// Optional burst lock is built when LMEM_ARB_LOCK_EN is defined.
module lmem_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 12,
    parameter int DW   = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [3*NREQ-1:0] sel,
    input  logic [AW*NREQ-1:0] addr,
    input  logic [DW*NREQ-1:0] wdata,
    input  logic [NREQ-1:0]   lock,
    output logic [NREQ-1:0]   gnt,
    output logic              rvalid,
    output logic [1:0]        rid,
    output logic [DW-1:0]     rdata,
    output logic [2:0]        csel,
    output logic              cwr,
    output logic [AW-1:0]     caddr_wr,
    output logic [DW-1:0]     cdata_wr,
    output logic              crd,
    output logic [AW-1:0]     caddr_rd,
    input  logic [DW-1:0]     cdata_rd
);

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

`ifdef LMEM_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    state_t          state, state_n;
    logic [1:0]      ptr, ptr_n;
    logic [1:0]      win;
    logic [1:0]      rd_id;
    logic            found;
    logic [NREQ-1:0] elig;

`ifdef LMEM_ARB_LOCK_EN
    logic [1:0] owner;

    // A locked owner that drops req hands back to round-robin the same cycle.
    always_comb begin
        elig = req & {NREQ{reset_n}};
        if (state == LOCKED && req[owner])
            elig = elig & (ONE << owner);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            owner <= '0;
        else if (found)
            owner <= win;
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign elig = req & {NREQ{reset_n}};
`endif

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
        gnt = found ? (ONE << win) : '0;
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        unique case (state)
            IDLE:    state_n = found ? GRANT : IDLE;
            GRANT:   state_n = found ? GRANT : IDLE;
`ifdef LMEM_ARB_LOCK_EN
            LOCKED:  state_n = found ? GRANT : IDLE;
`endif
            default: state_n = IDLE;
        endcase
`ifdef LMEM_ARB_LOCK_EN
        if (found && lock[win])
            state_n = LOCKED;
`endif
        if (found)
            ptr_n = (int'(win) + 1 >= NREQ) ? 2'd0 : win + 2'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            csel     <= '0;
            cwr      <= 1'b0;
            crd      <= 1'b0;
            caddr_wr <= '0;
            caddr_rd <= '0;
            cdata_wr <= '0;
            rd_id    <= '0;
            rvalid   <= 1'b0;
            rid      <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cwr   <= found && we[win];
            crd   <= found && !we[win];
            if (found) begin
                csel <= sel[3*win +: 3];
                if (we[win]) begin
                    caddr_wr <= addr[AW*win +: AW];
                    cdata_wr <= wdata[DW*win +: DW];
                end else begin
                    caddr_rd <= addr[AW*win +: AW];
                    rd_id    <= win;
                end
            end
            // Memory answers the cycle after crd, so the tag trails by one more.
            rvalid <= crd;
            rid    <= rd_id;
        end
    end

    assign rdata = cdata_rd;

endmodule

// File: tb/tb_lmem_arbiter.sv
// tb_lmem_arbiter: scoreboard bench for the layer-memory arbiter.
// Lock expectations follow LMEM_ARB_LOCK_EN when defined.
module tb_lmem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 20;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req, we, lock;
    logic [3*NREQ-1:0]   sel;
    logic [AW*NREQ-1:0]  addr;
    logic [DW*NREQ-1:0]  wdata;
    logic [NREQ-1:0]     gnt;
    logic                rvalid;
    logic [1:0]          rid;
    logic [DW-1:0]       rdata;
    logic [2:0]          csel;
    logic                cwr, crd;
    logic [AW-1:0]       caddr_wr, caddr_rd;
    logic [DW-1:0]       cdata_wr;
    logic [DW-1:0]       cdata_rd;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int            due;
        logic [1:0]    id;
        logic [DW-1:0] data;
    } rd_t;

    typedef struct {
        int            due;
        logic [AW-1:0] a;
    } cmd_t;

    rd_t  rd_q[$];
    cmd_t cmd_q[$];

    logic [DW-1:0] mem [0:4095];

    lmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req(req), .we(we), .sel(sel), .addr(addr),
        .wdata(wdata), .lock(lock), .gnt(gnt),
        .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (crd) cdata_rd <= mem[caddr_rd];

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_rq(input int i, input logic r, input logic w,
                          input logic lk, input logic [2:0] s,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]            = r;
        we[i]             = w;
        lock[i]           = lk;
        sel[3*i +: 3]     = s;
        addr[AW*i +: AW]  = a;
        wdata[DW*i +: DW] = d;
    endtask

    task automatic push_exp(input int w);
        rd_t  r;
        cmd_t c;
        if (we[w]) return;
        c.due  = cyc + 1;
        c.a    = addr[AW*w +: AW];
        r.due  = cyc + 2;
        r.id   = 2'(w);
        r.data = mem[addr[AW*w +: AW]];
        cmd_q.push_back(c);
        rd_q.push_back(r);
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) next();
    endtask

    function automatic int pick(input logic [2:0] r, input int p,
                                input bit lk, input int own);
        if (lk && r[own]) return own;
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        req = 3'b111; we = '0; lock = '0;
        sel = '0; addr = '0; wdata = '0;
        next(); next();
        checks++;
        if (gnt !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt: got %b want 000", gnt);
        end
        checks++;
        if ({csel, cwr, crd, caddr_wr, caddr_rd, cdata_wr, rvalid, rid} !== '0) begin
            errors++;
            $display("FAIL reset_bus: csel=%h cwr=%b crd=%b aw=%h ar=%h dw=%h rv=%b rid=%0d want all 0",
                     csel, cwr, crd, caddr_wr, caddr_rd, cdata_wr, rvalid, rid);
        end
        req = '0;
        next();
        reset_n = 1'b1;
        set_rq(0, 1'b0, 1'b0, 1'b0, 3'd5, 12'h010, '0);
        next();
        req[0] = 1'b1;
        #1;
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL reset_pre_gnt: got %b want 001", gnt);
        end
        next();
        req[0] = 1'b0;
        #1;
        checks++;
        if (crd !== 1'b1 || caddr_rd !== 12'h010 || csel !== 3'd5) begin
            errors++;
            $display("FAIL reset_pre_cmd: crd=%b ar=%h csel=%0d want 1 010 5",
                     crd, caddr_rd, csel);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, csel, cwr, crd, caddr_wr, caddr_rd, cdata_wr, rvalid, rid} !== '0) begin
            errors++;
            $display("FAIL reset_async: crd=%b ar=%h csel=%h rv=%b want all 0",
                     crd, caddr_rd, csel, rvalid);
        end
        next();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next();
            checks++;
            if (rvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_rvalid: cycle %0d rvalid=%b want 0", i, rvalid);
            end
        end
    endtask

    task automatic test_round_robin();
        int          exp_w [4];
        logic [2:0]  exp_g;
        rd_t         re;
        cmd_t        ce;
        exp_w = '{0, 1, 2, 0};
        mem[12'h010] = 20'h11111;
        mem[12'h020] = 20'h22222;
        mem[12'h030] = 20'h33333;
        set_rq(0, 1'b0, 1'b0, 1'b0, 3'd1, 12'h010, '0);
        set_rq(1, 1'b0, 1'b0, 1'b0, 3'd2, 12'h020, '0);
        set_rq(2, 1'b0, 1'b0, 1'b0, 3'd3, 12'h030, '0);
        for (int c = 0; c < 7; c++) begin
            next();
            req = (c < 4) ? 3'b111 : 3'b000;
            #1;
            exp_g = (c < 4) ? (3'b001 << exp_w[c]) : 3'b000;
            checks++;
            if (gnt !== exp_g) begin
                errors++;
                $display("FAIL rr_gnt: cycle %0d got %b want %b", c, gnt, exp_g);
            end
            if (c < 4) push_exp(exp_w[c]);
            if (cmd_q.size() != 0 && cmd_q[0].due == cyc) begin
                ce = cmd_q.pop_front();
                checks++;
                if (crd !== 1'b1 || cwr !== 1'b0 || caddr_rd !== ce.a) begin
                    errors++;
                    $display("FAIL rr_cmd: crd=%b cwr=%b ar=%h want 1 0 %h",
                             crd, cwr, caddr_rd, ce.a);
                end
            end
            if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
                re = rd_q.pop_front();
                checks++;
                if (rvalid !== 1'b1 || rid !== re.id || rdata !== re.data) begin
                    errors++;
                    $display("FAIL rr_rdata: rv=%b rid=%0d rdata=%h want 1 %0d %h",
                             rvalid, rid, rdata, re.id, re.data);
                end
            end else begin
                checks++;
                if (rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_idle_rvalid: cycle %0d rvalid=%b want 0", c, rvalid);
                end
            end
        end
        checks++;
        if (rd_q.size() != 0 || cmd_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: %0d reads %0d cmds left want 0 0",
                     rd_q.size(), cmd_q.size());
        end
        rd_q.delete();
        cmd_q.delete();
    endtask

    task automatic test_write();
        set_rq(0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, '0);
        set_rq(2, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, '0);
        set_rq(1, 1'b0, 1'b1, 1'b0, 3'b011, 12'h3FF, 20'h0ABCD);
        next();
        req[1] = 1'b1;
        #1;
        checks++;
        if (gnt !== 3'b010) begin
            errors++;
            $display("FAIL wr_gnt: got %b want 010", gnt);
        end
        next();
        req[1] = 1'b0;
        #1;
        checks++;
        if (cwr !== 1'b1 || crd !== 1'b0 || csel !== 3'd3 ||
            caddr_wr !== 12'h3FF || cdata_wr !== 20'h0ABCD) begin
            errors++;
            $display("FAIL wr_cmd: cwr=%b crd=%b csel=%0d aw=%h dw=%h want 1 0 3 3ff 0abcd",
                     cwr, crd, csel, caddr_wr, cdata_wr);
        end
        next();
        checks++;
        if (cwr !== 1'b0 || crd !== 1'b0 || csel !== 3'd3 ||
            caddr_wr !== 12'h3FF || cdata_wr !== 20'h0ABCD) begin
            errors++;
            $display("FAIL wr_hold: cwr=%b crd=%b csel=%0d aw=%h dw=%h want 0 0 3 3ff 0abcd",
                     cwr, crd, csel, caddr_wr, cdata_wr);
        end
    endtask

    task automatic test_withdraw();
        logic [2:0] rq [6];
        logic [2:0] ex [6];
        rq = '{3'b100, 3'b101, 3'b001, 3'b000, 3'b111, 3'b000};
        ex = '{3'b100, 3'b001, 3'b001, 3'b000, 3'b010, 3'b000};
        set_rq(0, 1'b0, 1'b0, 1'b0, 3'd1, 12'h070, '0);
        set_rq(1, 1'b0, 1'b0, 1'b0, 3'd1, 12'h080, '0);
        set_rq(2, 1'b0, 1'b0, 1'b0, 3'd1, 12'h060, '0);
        for (int c = 0; c < 6; c++) begin
            next();
            req = rq[c];
            #1;
            checks++;
            if (gnt !== ex[c]) begin
                errors++;
                $display("FAIL wd_gnt: step %0d got %b want %b", c, gnt, ex[c]);
            end
        end
        idle(3);
    endtask

    task automatic test_lock();
        int   n0, n1, w, m_ptr, m_own;
        bit   m_lk;
        logic [2:0] exp_g;
        rd_t  re;
        cmd_t ce;
        for (int i = 0; i < 5; i++) mem[12'h050 + i] = 20'h50000 + i;
        mem[12'h040] = 20'h40404;
        set_rq(0, 1'b0, 1'b0, 1'b0, 3'd4, 12'h040, '0);
        set_rq(1, 1'b0, 1'b0, 1'b0, 3'd2, 12'h050, '0);
        set_rq(2, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, '0);
        next();
        req = 3'b001;
        #1;
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL lk_pre_gnt: got %b want 001", gnt);
        end
        n0 = 0; n1 = 0; m_ptr = 1; m_lk = 1'b0; m_own = 0;
        for (int c = 0; c < 9; c++) begin
            next();
            set_rq(0, n0 < 1, 1'b0, 1'b0, 3'd4, 12'h040, '0);
            set_rq(1, n1 < 5, n1 == 4, n1 < 4, 3'd2,
                   12'h050 + 12'(n1), 20'h12345);
            #1;
            w = pick(req, m_ptr, m_lk, m_own);
            exp_g = (w < 0) ? 3'b000 : (3'b001 << w);
            checks++;
            if (gnt !== exp_g) begin
                errors++;
                $display("FAIL lk_gnt: cycle %0d got %b want %b", c, gnt, exp_g);
            end
            if (w >= 0) push_exp(w);
            if (cmd_q.size() != 0 && cmd_q[0].due == cyc) begin
                ce = cmd_q.pop_front();
                checks++;
                if (crd !== 1'b1 || cwr !== 1'b0 || caddr_rd !== ce.a) begin
                    errors++;
                    $display("FAIL lk_cmd: crd=%b cwr=%b ar=%h want 1 0 %h",
                             crd, cwr, caddr_rd, ce.a);
                end
            end
            if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
                re = rd_q.pop_front();
                checks++;
                if (rvalid !== 1'b1 || rid !== re.id || rdata !== re.data) begin
                    errors++;
                    $display("FAIL lk_rdata: rv=%b rid=%0d rdata=%h want 1 %0d %h",
                             rvalid, rid, rdata, re.id, re.data);
                end
            end
            if (w >= 0) begin
                m_ptr = (w + 1) % 3;
                m_own = w;
`ifdef LMEM_ARB_LOCK_EN
                m_lk = lock[w];
`endif
                if (w == 0) n0++;
                if (w == 1) n1++;
            end else begin
                m_lk = 1'b0;
            end
        end
        checks++;
        if (rd_q.size() != 0 || n0 != 1 || n1 != 5) begin
            errors++;
            $display("FAIL lk_done: reads_left=%0d n0=%0d n1=%0d want 0 1 5",
                     rd_q.size(), n0, n1);
        end
        rd_q.delete();
        cmd_q.delete();
        idle(2);
    endtask

    task automatic test_read_data();
        rd_t  re;
        cmd_t ce;
        mem[12'h0AB] = 20'hFFFFF;
        set_rq(0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, '0);
        set_rq(1, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, '0);
        set_rq(2, 1'b0, 1'b0, 1'b0, 3'd6, 12'h0AB, '0);
        for (int c = 0; c < 4; c++) begin
            next();
            req = (c == 0) ? 3'b100 : 3'b000;
            #1;
            if (c == 0) begin
                checks++;
                if (gnt !== 3'b100) begin
                    errors++;
                    $display("FAIL rd_gnt: got %b want 100", gnt);
                end
                push_exp(2);
            end
            if (cmd_q.size() != 0 && cmd_q[0].due == cyc) begin
                ce = cmd_q.pop_front();
                checks++;
                if (crd !== 1'b1 || caddr_rd !== ce.a || csel !== 3'd6) begin
                    errors++;
                    $display("FAIL rd_cmd: crd=%b ar=%h csel=%0d want 1 %h 6",
                             crd, caddr_rd, csel, ce.a);
                end
            end
            if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
                re = rd_q.pop_front();
                checks++;
                if (rvalid !== 1'b1 || rid !== re.id || rdata !== re.data) begin
                    errors++;
                    $display("FAIL rd_data: rv=%b rid=%0d rdata=%h want 1 %0d %h",
                             rvalid, rid, rdata, re.id, re.data);
                end
            end else begin
                checks++;
                if (rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_idle_rvalid: cycle %0d rvalid=%b want 0", c, rvalid);
                end
            end
        end
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL rd_drain: %0d reads left want 0", rd_q.size());
        end
        rd_q.delete();
        cmd_q.delete();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write();
        test_withdraw();
        test_lock();
        test_read_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
